// File: rtl/tube_pkg.sv
// Shared constants and types for the tube display arbiter.
package tube_pkg;

    localparam int DIGIT_W = 4;
    localparam int DIGITS  = 4;
    localparam int REQ_W   = DIGIT_W * DIGITS;

    localparam int HOLD_CYCLES_DEF = 1000000;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/tube_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after last_id, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    input  logic [N_REQ-1:0] excl,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Walk from the farthest candidate to the nearest so the nearest one wins.
        for (int k = N_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_id) + k) % N_REQ;
            if (req[idx] && !excl[idx]) begin
                valid = 1'b1;
                id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tube_arbiter.sv
// Round-robin arbiter with minimum hold time sharing one 4-digit tube driver.
// Optional TUBE_ARB_PRIO_EN makes requester 0 urgent (preempts, never rotated away).
module tube_arbiter
    import tube_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [REQ_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [DIGIT_W-1:0]       data0,
    output logic [DIGIT_W-1:0]       data1,
    output logic [DIGIT_W-1:0]       data2,
    output logic [DIGIT_W-1:0]       data3,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] cur_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REQ_W-1:0]   disp_q, disp_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic               grant_new;
    logic               preempt;
    logic               pin;
    logic [ID_W-1:0]    sel_id;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req     (req),
        .last_id (last_id_q),
        .excl    (gnt_q),
        .valid   (pick_valid),
        .id      (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        cnt_d     = cnt_q;
        disp_d    = disp_q;
        grant_new = 1'b0;
        win_valid = pick_valid;
        win_id    = pick_id;
`ifdef TUBE_ARB_PRIO_EN
        preempt = req[0] && (cur_id_q != '0);
        pin     = (cur_id_q == '0);
        if (req[0]) begin
            win_valid = 1'b1;
            win_id    = '0;
        end
`else
        preempt = 1'b0;
        pin     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                grant_new = win_valid;
            end
            GRANT: begin
                // A drop wins over expiry; a waiter takes over with no idle gap.
                if (!req[cur_id_q]) begin
                    if (win_valid) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (preempt) begin
                    grant_new = 1'b1;
                end else if (!pin && cnt_q == '0 && win_valid) begin
                    grant_new = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_new) begin
            state_d   = GRANT;
            gnt_d     = N_REQ'(1) << win_id;
            cur_id_d  = win_id;
            last_id_d = win_id;
            cnt_d     = CNT_W'(HOLD_CYCLES - 1);
        end

        // Digits follow the (new) holder every cycle; IDLE keeps the last value.
        sel_id = grant_new ? win_id : cur_id_q;
        if (state_d == GRANT) begin
            disp_d = req_data[int'(sel_id) * REQ_W +: REQ_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            cur_id_q  <= '0;
            last_id_q <= ID_W'(N_REQ - 1);
            cnt_q     <= '0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            cnt_q     <= cnt_d;
            disp_q    <= disp_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = (state_q == GRANT);
    assign cur_id = cur_id_q;
    assign data0  = disp_q[0*DIGIT_W +: DIGIT_W];
    assign data1  = disp_q[1*DIGIT_W +: DIGIT_W];
    assign data2  = disp_q[2*DIGIT_W +: DIGIT_W];
    assign data3  = disp_q[3*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_tube_arbiter.sv
// Directed self-checking bench for tube_arbiter (N_REQ=4, HOLD_CYCLES=8).
module tb_tube_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  data0, data1, data2, data3;
    logic        busy;
    logic [1:0]  cur_id;

    int tests_run;
    int tests_failed;

    tube_arbiter #(.N_REQ(4), .HOLD_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .data3    (data3),
        .busy     (busy),
        .cur_id   (cur_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        req      = 4'b0000;
        req_data = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        req      = 4'b0000;
        req_data = 64'h1111_2222_3333_4444;
        #2;
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || cur_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got gnt=%b busy=%b id=%0d want 0000/0/0", gnt, busy, cur_id);
        end
        tests_run++;
        if ({data3, data2, data1, data0} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0000", {data3, data2, data1, data0});
        end
        step();
        rst = 1'b1;
        step();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_data[15:0] = 16'h4321;
        req = 4'b0001;
        step();
        tests_run++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || cur_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_gnt: got gnt=%b busy=%b id=%0d want 0001/1/0", gnt, busy, cur_id);
        end
        tests_run++;
        if ({data3, data2, data1, data0} !== 16'h4321) begin
            tests_failed++;
            $display("FAIL single_data: got %h want 4321", {data3, data2, data1, data0});
        end
        for (int i = 0; i < 12; i++) begin
            step();
            tests_run++;
            if (gnt !== 4'b0001) begin
                tests_failed++;
                $display("FAIL single_hold[%0d]: got %b want 0001", i, gnt);
            end
        end
        req = 4'b0000;
        step();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
        end
        tests_run++;
        if ({data3, data2, data1, data0} !== 16'h4321) begin
            tests_failed++;
            $display("FAIL single_keep: got %h want 4321", {data3, data2, data1, data0});
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp;
        do_reset();
        req = 4'b0011;
        for (int s = 1; s <= 24; s++) begin
            step();
`ifdef TUBE_ARB_PRIO_EN
            exp = 4'b0001;
`else
            exp = (s >= 9 && s <= 16) ? 4'b0010 : 4'b0001;
`endif
            tests_run++;
            if (gnt !== exp) begin
                tests_failed++;
                $display("FAIL contention[%0d]: got %b want %b", s, gnt, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp;
        do_reset();
        req = 4'b1000;
        step();
        tests_run++;
        if (gnt !== 4'b1000 || cur_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL wrap_first: got gnt=%b id=%0d want 1000/3", gnt, cur_id);
        end
        req = 4'b0000;
        step();
        req = 4'b1001;
        step();
        tests_run++;
        if (gnt !== 4'b0001 || cur_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL wrap_zero: got gnt=%b id=%0d want 0001/0", gnt, cur_id);
        end
        for (int s = 2; s <= 9; s++) begin
            step();
`ifdef TUBE_ARB_PRIO_EN
            exp = 4'b0001;
`else
            exp = (s == 9) ? 4'b1000 : 4'b0001;
`endif
            tests_run++;
            if (gnt !== exp) begin
                tests_failed++;
                $display("FAIL wrap_rot[%0d]: got %b want %b", s, gnt, exp);
            end
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        req_data[47:32] = 16'h9876;
        req = 4'b0110;
        step();
        tests_run++;
        if (gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL drop_first: got %b want 0010", gnt);
        end
        step();
        step();
        req = 4'b0100;
        step();
        tests_run++;
        if (gnt !== 4'b0100 || cur_id !== 2'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_handover: got gnt=%b id=%0d busy=%b want 0100/2/1", gnt, cur_id, busy);
        end
        tests_run++;
        if ({data3, data2, data1, data0} !== 16'h9876) begin
            tests_failed++;
            $display("FAIL drop_data: got %h want 9876", {data3, data2, data1, data0});
        end
    endtask

    task automatic test_live();
        do_reset();
        req_data[31:16] = 16'h8521;
        req = 4'b0010;
        step();
        tests_run++;
        if ({data3, data2, data1, data0} !== 16'h8521) begin
            tests_failed++;
            $display("FAIL live_init: got %h want 8521", {data3, data2, data1, data0});
        end
        req_data[31:16] = 16'h8721;
        #2;
        tests_run++;
        if (data2 !== 4'd5) begin
            tests_failed++;
            $display("FAIL live_lag: got %0d want 5", data2);
        end
        step();
        tests_run++;
        if (data2 !== 4'd7) begin
            tests_failed++;
            $display("FAIL live_update: got %0d want 7", data2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = 64'h0000_3333_0000_5555;
        req = 4'b0001;
        step();
        step();
        rst = 1'b0;
        #1;
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || cur_id !== 2'd0 ||
            {data3, data2, data1, data0} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid: got gnt=%b busy=%b id=%0d data=%h want all zero",
                     gnt, busy, cur_id, {data3, data2, data1, data0});
        end
        req = 4'b0000;
        step();
        rst = 1'b1;
        req = 4'b0100;
        step();
        tests_run++;
        if (gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL post_reset_gnt: got %b want 0100", gnt);
        end
        step();
        req = 4'b0101;
        step();
        tests_run++;
`ifdef TUBE_ARB_PRIO_EN
        if (gnt !== 4'b0001) begin
            tests_failed++;
            $display("FAIL prio_preempt: got %b want 0001", gnt);
        end
`else
        if (gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL no_preempt: got %b want 0100", gnt);
        end
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        req          = 4'b0000;
        req_data     = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_early_drop();
        test_live();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
